// File: rtl/wave_pkg.sv
// Shared types for the wave datapath: FSM state encoding and the amp/freq/phase/period set
// held in both the shadow and active registers of wave_timebase.
package wave_pkg;
   localparam int W_DEFAULT = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic [W_DEFAULT-1:0] amp;
      logic [W_DEFAULT-1:0] freq;
      logic [W_DEFAULT-1:0] phase;
      logic [W_DEFAULT-1:0] period;
   } wave_cfg_t;
endpackage

// File: rtl/wave_timebase_if.sv
// Config offer channel into wave_timebase: valid/ready carrying one amp/freq/phase/period set.
interface wave_timebase_if #(
   parameter int W = wave_pkg::W_DEFAULT
);
   logic         cfg_valid;
   logic         cfg_ready;
   logic [W-1:0] cfg_amp;
   logic [W-1:0] cfg_freq;
   logic [W-1:0] cfg_phase;
   logic [W-1:0] cfg_period;

   modport master (
      output cfg_valid, cfg_amp, cfg_freq, cfg_phase, cfg_period,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_amp, cfg_freq, cfg_phase, cfg_period,
      output cfg_ready
   );
endinterface

// File: rtl/wave_tick_div.sv
// Free-running 0..CLK_DIV-1 cycle counter with synchronous clear; tc is high on the last count.
module wave_tick_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tc
);
   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || (cnt_q == LAST)) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tc = (cnt_q == LAST);
endmodule

// File: rtl/wave_timebase.sv
// Sample-index timebase; config sets arrive via handshake and are applied only when t wraps.
// Optional macro WAVE_TB_SYNC_EN adds sync_in, whose rising edge restarts the period.
module wave_timebase
   import wave_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int W       = W_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           enable,
`ifdef WAVE_TB_SYNC_EN
   input  logic           sync_in,
`endif
   wave_timebase_if.slave cfg,
   output logic [W-1:0]   amp,
   output logic [W-1:0]   freq,
   output logic [W-1:0]   phase,
   output logic [W-1:0]   t,
   output logic           sample_stb,
   output logic           running
);
   state_e       state_q, state_d;
   logic [W-1:0] t_q, t_d;
   logic         stb_q, stb_d;
   wave_cfg_t    active_q, active_d, shadow_q, shadow_d;
   logic         pending_q, pending_d;
   logic         cfg_ready_q, cfg_ready_d;
   logic         tick, div_clr, sync_fire, apply, xfer;
   logic [W-1:0] last_t;

   wave_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (div_clr),
      .tc    (tick)
   );

`ifdef WAVE_TB_SYNC_EN
   // Two synchroniser flops plus one history flop for rising-edge detection.
   logic [2:0] sync_q, sync_d;
   assign sync_d = {sync_q[1:0], sync_in};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
   end
   assign sync_fire = (state_q == RUN) && sync_q[1] && !sync_q[2];
`else
   assign sync_fire = 1'b0;
`endif

   assign div_clr = (state_q != RUN) || !enable || sync_fire;
   assign last_t  = W'(active_q.period - W_DEFAULT'(1));
   assign xfer    = cfg.cfg_valid && cfg_ready_q;

   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      stb_d    = 1'b0;
      active_d = active_q;
      shadow_d = shadow_q;
      apply    = 1'b0;
      unique case (state_q)
         IDLE: begin
            t_d   = '0;
            apply = pending_q;
            if (enable) begin
               state_d = RUN;
               stb_d   = 1'b1;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
               t_d     = '0;
            end else if (sync_fire) begin
               t_d   = '0;
               stb_d = 1'b1;
               apply = pending_q;
            end else if (tick) begin
               stb_d = 1'b1;
               if (t_q == last_t) begin
                  t_d   = '0;
                  apply = pending_q;
               end else begin
                  t_d = t_q + W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A transfer needs cfg_ready (no pending), so it never coincides with an apply.
      pending_d = pending_q;
      if (apply) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (xfer) begin
         shadow_d.amp    = W_DEFAULT'(cfg.cfg_amp);
         shadow_d.freq   = W_DEFAULT'(cfg.cfg_freq);
         shadow_d.phase  = W_DEFAULT'(cfg.cfg_phase);
         shadow_d.period = W_DEFAULT'(cfg.cfg_period);
         pending_d       = 1'b1;
      end
      cfg_ready_d = !pending_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         t_q         <= '0;
         stb_q       <= 1'b0;
         active_q    <= '0;
         shadow_q    <= '0;
         pending_q   <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         stb_q       <= stb_d;
         active_q    <= active_d;
         shadow_q    <= shadow_d;
         pending_q   <= pending_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign cfg.cfg_ready = cfg_ready_q;
   assign amp           = W'(active_q.amp);
   assign freq          = W'(active_q.freq);
   assign phase         = W'(active_q.phase);
   assign t             = t_q;
   assign sample_stb    = stb_q;
   assign running       = (state_q == RUN);
endmodule

// File: tb/tb_wave_timebase.sv
// Bench for wave_timebase: directed scenarios plus random traffic against a sample-level model.
module tb_wave_timebase;
   localparam int CLK_DIV = 4;
   localparam int W       = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0;
`ifdef WAVE_TB_SYNC_EN
   logic sync_in = 1'b0;
`endif
   logic [W-1:0] amp, freq, phase, t;
   logic         sample_stb, running;

   wave_timebase_if #(.W(W)) cfg_if ();

   wave_timebase #(.CLK_DIV(CLK_DIV), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
`ifdef WAVE_TB_SYNC_EN
      .sync_in    (sync_in),
`endif
      .cfg        (cfg_if),
      .amp        (amp),
      .freq       (freq),
      .phase      (phase),
      .t          (t),
      .sample_stb (sample_stb),
      .running    (running)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: run flag, cycles since last strobe, sample index, parameter sets.
   int m_run, m_since, m_t, m_stb, m_pend;
   int m_act[4];
   int m_sh[4];
   int m_sync[3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_since = 0; m_t = 0; m_stb = 0; m_pend = 0;
      m_act = '{0, 0, 0, 0};
      m_sh  = '{0, 0, 0, 0};
      m_sync = '{0, 0, 0};
   endtask

   function automatic int cur_period();
      return (m_act[3] == 0) ? 65536 : m_act[3];
   endfunction

   task automatic model_edge();
      bit xfer, apply, fire;
      xfer  = cfg_if.cfg_valid && (m_pend == 0);
      apply = 0;
      fire  = 0;
`ifdef WAVE_TB_SYNC_EN
      fire = (m_run != 0) && (m_sync[1] != 0) && (m_sync[2] == 0);
      m_sync[2] = m_sync[1];
      m_sync[1] = m_sync[0];
      m_sync[0] = int'(sync_in);
`endif
      m_stb = 0;
      if (m_run == 0) begin
         apply = (m_pend != 0);
         m_t = 0;
         if (enable) begin
            m_run = 1; m_since = 0; m_stb = 1;
         end
      end else if (!enable) begin
         m_run = 0; m_t = 0;
      end else if (fire) begin
         m_since = 0; m_t = 0; m_stb = 1;
         apply = (m_pend != 0);
      end else begin
         m_since++;
         if (m_since == CLK_DIV) begin
            m_since = 0;
            m_stb = 1;
            m_t = (m_t + 1) % cur_period();
            if (m_t == 0) apply = (m_pend != 0);
         end
      end
      if (apply) begin
         m_act = m_sh;
         m_pend = 0;
      end
      if (xfer) begin
         m_sh = '{int'(cfg_if.cfg_amp), int'(cfg_if.cfg_freq),
                  int'(cfg_if.cfg_phase), int'(cfg_if.cfg_period)};
         m_pend = 1;
      end
   endtask

   function automatic bit wrap_next();
      return (m_run != 0) && enable && (m_since == CLK_DIV - 1)
             && ((m_t + 1) % cur_period() == 0);
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("t",         32'(t),                32'(m_t));
      chk("stb",       32'(sample_stb),       32'(m_stb));
      chk("running",   32'(running),          32'(m_run));
      chk("amp",       32'(amp),              32'(m_act[0]));
      chk("freq",      32'(freq),             32'(m_act[1]));
      chk("phase",     32'(phase),            32'(m_act[2]));
      chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_pend == 0));
   endtask

   task automatic offer(input int a, input int f, input int p, input int per);
      cfg_if.cfg_valid  = 1'b1;
      cfg_if.cfg_amp    = 16'(a);
      cfg_if.cfg_freq   = 16'(f);
      cfg_if.cfg_phase  = 16'(p);
      cfg_if.cfg_period = 16'(per);
   endtask

   initial begin
      int n, k;
      int tq[$];
      int exp_seq[6];
      exp_seq = '{0, 1, 2, 3, 4, 0};
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_amp = '0; cfg_if.cfg_freq = '0; cfg_if.cfg_phase = '0; cfg_if.cfg_period = '0;
      enable = 1'b1;
      rst_n  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_t",     32'(t),                32'd0);
      chk("rst_stb",   32'(sample_stb),       32'd0);
      chk("rst_run",   32'(running),          32'd0);
      chk("rst_amp",   32'(amp),              32'd0);
      chk("rst_freq",  32'(freq),             32'd0);
      chk("rst_phase", 32'(phase),            32'd0);
      chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
      rst_n = 1'b1;

      // Strobes at cycles 1,5,9,13 after release with t counting up.
      for (int c = 1; c <= 13; c++) begin
         step();
         chk("stb_cycle", 32'(sample_stb), 32'((c - 1) % CLK_DIV == 0));
         chk("t_cycle",   32'(t),          32'((c - 1) / CLK_DIV));
      end

      // Config in IDLE, then run with period 5.
      enable = 1'b0;
      step();
      offer(100, 3, 7, 5);
      step();
      cfg_if.cfg_valid = 1'b0;
      step();
      chk("idle_amp",   32'(amp),              32'd100);
      chk("idle_freq",  32'(freq),             32'd3);
      chk("idle_phase", 32'(phase),            32'd7);
      chk("idle_ready", 32'(cfg_if.cfg_ready), 32'd1);
      enable = 1'b1;
      n = 0;
      while (tq.size() < 6 && n < 40) begin
         step();
         if (sample_stb) tq.push_back(int'(t));
         n++;
      end
      chk("seq_len", 32'(tq.size()), 32'd6);
      for (int i = 0; i < 6 && i < tq.size(); i++) chk("seq_t", 32'(tq[i]), 32'(exp_seq[i]));

      // Mid-period offer at t=2: held until the wrap, repeated valid not captured.
      n = 0;
      while (!(sample_stb && t == 2) && n < 40) begin step(); n++; end
      chk("wait_t2", 32'(n < 40), 32'd1);
      offer(200, 3, 7, 5);
      step();
      cfg_if.cfg_amp = 16'd999;
      n = 0;
      while (!(sample_stb && t == 0) && n < 30) begin
         chk("amp_hold",  32'(amp),              32'd100);
         chk("ready_low", 32'(cfg_if.cfg_ready), 32'd0);
         if (n == 2) cfg_if.cfg_valid = 1'b0;
         step();
         n++;
      end
      chk("wait_wrap1", 32'(n < 30), 32'd1);
      chk("amp_new",    32'(amp),    32'd200);
      step();
      chk("ready_back", 32'(cfg_if.cfg_ready), 32'd1);

      // Handshake on the exact wrap edge: applied one full period later.
      n = 0;
      while (!wrap_next() && n < 40) begin step(); n++; end
      chk("wait_wrapedge", 32'(n < 40), 32'd1);
      offer(300, 4, 8, 5);
      step();
      cfg_if.cfg_valid = 1'b0;
      chk("wrapedge_t",   32'(t),   32'd0);
      chk("wrapedge_amp", 32'(amp), 32'd200);
      k = 0; n = 0;
      while (k < 5 && n < 40) begin
         step();
         n++;
         if (sample_stb) begin
            k++;
            if (k < 5) chk("late_amp_old", 32'(amp), 32'd200);
         end
      end
      chk("late_strobes", 32'(k),   32'd5);
      chk("late_t",       32'(t),   32'd0);
      chk("late_amp_new", 32'(amp), 32'd300);

      // Drop enable at t=3 and bring it back.
      n = 0;
      while (!(sample_stb && t == 3) && n < 40) begin step(); n++; end
      chk("wait_t3", 32'(n < 40), 32'd1);
      enable = 1'b0;
      step();
      chk("off_running", 32'(running), 32'd0);
      chk("off_t",       32'(t),       32'd0);
      enable = 1'b1;
      step();
      chk("on_running", 32'(running),    32'd1);
      chk("on_stb",     32'(sample_stb), 32'd1);
      chk("on_t",       32'(t),          32'd0);

`ifdef WAVE_TB_SYNC_EN
      // Sync pulse at t=3 with a pending set.
      n = 0;
      while (!(sample_stb && t == 3) && n < 40) begin step(); n++; end
      chk("sync_wait_t3", 32'(n < 40), 32'd1);
      offer(85, 1, 2, 5);
      step();
      cfg_if.cfg_valid = 1'b0;
      sync_in = 1'b1;
      step();
      sync_in = 1'b0;
      n = 1;
      while (!(sample_stb && t == 0) && n < 4) begin step(); n++; end
      chk("sync_latency", 32'(n <= 3), 32'd1);
      chk("sync_amp",     32'(amp),    32'd85);
`endif

      // Random traffic.
      for (int c = 0; c < 800; c++) begin
         int pr;
         pr = $urandom_range(0, 5);
         enable = ($urandom_range(0, 99) < 97);
         offer(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 65535)),
               (pr == 0) ? 0 : (pr == 1) ? 1 : int'($urandom_range(2, 6)));
         cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
`ifdef WAVE_TB_SYNC_EN
         sync_in = ($urandom_range(0, 19) == 0);
`endif
         step();
      end
      cfg_if.cfg_valid = 1'b0;
`ifdef WAVE_TB_SYNC_EN
      sync_in = 1'b0;
`endif

      // Reset mid-run with a pending set: everything returns to reset values.
      enable = 1'b1;
      repeat (3) step();
      offer(4242, 1, 1, 3);
      step();
      cfg_if.cfg_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("mid_rst_t",     32'(t),                32'd0);
      chk("mid_rst_run",   32'(running),          32'd0);
      chk("mid_rst_amp",   32'(amp),              32'd0);
      chk("mid_rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
      @(posedge clk);
      #1;
      enable = 1'b0;
      rst_n = 1'b1;
      model_reset();
      repeat (3) step();
      chk("lost_amp", 32'(amp), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wave_timebase.md
Name: wave_timebase

Overview:
- Upstream stage of the wave compute datapath.
- Generates the sample index t at a programmable sample rate.
- Holds the active amp/freq/phase set, so the combinational compute stage downstream sees stable operands.
- New parameter sets enter through a valid/ready handshake and are applied phase-coherently at t wrap, so the waveform never glitches mid-period.

Parameters:
- CLK_DIV, 4, clock cycles per sample; legal range 1..65535.
- W, 16, width of amp/freq/phase/t/period.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request; level-sensitive.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  block can accept config.
- cfg_amp  in  W  new amplitude.
- cfg_freq  in  W  new frequency.
- cfg_phase  in  W  new phase.
- cfg_period  in  W  new t wrap length; 0 means 2^W.
- amp  out  W  active amplitude.
- freq  out  W  active frequency.
- phase  out  W  active phase.
- t  out  W  current sample index.
- sample_stb  out  1  one-cycle pulse when t takes a new value; downstream result is valid this cycle.
- running  out  1  high in RUN state.

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except cfg_ready=1; active period=0 (2^W); divider=0; pending=0; state IDLE.
- Config handshake:
  - Transfer occurs when cfg_valid&&cfg_ready at a rising edge; the four cfg_* values are captured into shadow registers and pending=1.
  - cfg_ready = !pending, registered.
  - cfg_ready falls the cycle after the transfer and rises the cycle after the shadow is applied.
- FSM states:
  - IDLE: t=0, divider=0, sample_stb=0. If pending, apply shadow to active on the next edge (pending cleared). If enable=1, go to RUN.
  - RUN: entry cycle drives t=0 with sample_stb=1. Divider counts 0..CLK_DIV-1; sample_stb=1 for the cycle after the divider reaches CLK_DIV-1, so strobes are exactly CLK_DIV cycles apart. On each strobe, t <= t+1, or t <= 0 if t == period-1 (period 0 wraps at 2^W-1 -> 0).
  - If pending=1 at the edge that wraps t to 0, the shadow is applied on that same edge: amp/freq/phase/period change together with t=0.
  - enable=0 in RUN -> IDLE on the next edge; t and divider cleared; pending retained and then applied per IDLE rule.
- Boundary conditions:
  - Handshake on the same edge as a wrap: the newly captured set is NOT applied at that wrap, only at the next one.
  - Active-set change during a period is impossible by construction.
  - CLK_DIV=1: sample_stb is high every cycle in RUN.
  - cfg_period=1: t is constantly 0; config applies at every strobe.
  - Arithmetic: all counters unsigned W bits with natural wrap; no saturation.
  - Reset mid-run: immediate return to reset values; shadow and pending are lost.

Optional Feature:
- Macro WAVE_TB_SYNC_EN.
- Defined:
  - Adds input sync_in (1 bit), synchronised by two flops.
  - A rising edge of the synchronised signal in RUN forces t=0, divider=0 and sample_stb=1 on the following edge, and applies the shadow if pending.
  - Sync in IDLE is ignored.
  - Sync simultaneous with a natural wrap produces a single strobe and a single apply.
- Undefined: port absent; t free-runs as above.

Decomposition:
- Package wave_pkg:
  - Width constant W_DEFAULT=16.
  - State typedef {IDLE, RUN}.
  - Struct wave_cfg_t {amp, freq, phase, period} for shadow/active registers; shared with the compute stage.
- Sub-module wave_tick_div:
  - Parameterised CLK_DIV counter with clear input.
  - Outputs a terminal-count pulse.

Test Plan:
- Reset with enable=1 held, CLK_DIV=4: outputs 0, cfg_ready=1. After release, sample_stb at cycles 1,5,9,… and t=0,1,2,…; period=0 wraps 65535->0.
- Idle config amp=100, freq=3, phase=7, period=5, then enable: active set visible before first strobe; t sequence 0,1,2,3,4,0; cfg_ready back to 1.
- In RUN, offer amp=200 at t=2: amp stays 100 until the edge where t becomes 0, then 200. cfg_valid held during pending sees cfg_ready=0 with no second capture.
- Handshake on the exact wrap edge: new set applied one full period (5 strobes) later.
- Deassert enable at t=3, then reassert: t returns 0, running=0 for one cycle, and the first strobe comes on re-entry with t=0.
- With WAVE_TB_SYNC_EN, pulse sync_in at t=3: t=0 with a strobe within 3 cycles of the pulse; a pending config is applied on that edge.
